gcd_engine: RTL and testbench

GCD_ENGINE -- requirements
Module: gcd_engine

---
 rtl/gcd_pkg.sv | 20 ++
 rtl/gcd_step.sv | 63 ++++++
 rtl/gcd_engine.sv | 128 ++++++++++++
 tb/tb_gcd_engine.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the binary GCD engine.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package gcd_pkg;

  // Engine control states; one datapath step is taken per cycle in SHIFT/REDUCE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } gcdState_e;

  // Worst-case cycles from request acceptance to out_valid for a given operand width.
  function automatic int latencyBound(input int width);
    return 3 * width + 3;
  endfunction

endpackage

// File: rtl/gcd_step.sv
`timescale 1ns/1ps
// Combinational single step of Stein's GCD: common-factor extraction or one reduction.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to commit the step.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int KW    = 5
) (
  input  logic             reduceMode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] aNext,
  output logic [WIDTH-1:0] bNext,
  output logic [KW-1:0]    kNext,
  output logic             done,
  output logic             toReduce,
  output logic [WIDTH-1:0] result,
  output logic             bothZero
);

  // One step: SHIFT strips shared factors of two, REDUCE applies the first matching rule.
  always_comb begin
    aNext    = a;
    bNext    = b;
    kNext    = k;
    done     = 1'b0;
    toReduce = 1'b0;
    result   = '0;
    bothZero = 1'b0;
    if (!reduceMode) begin
      if (a == '0 || b == '0) begin
        // gcd(x,0)=x; OR picks whichever operand is nonzero.
        done     = 1'b1;
        result   = a | b;
        bothZero = (a == '0) && (b == '0);
      end else if (!a[0] && !b[0]) begin
        aNext = a >> 1;
        bNext = b >> 1;
        kNext = k + KW'(1);
      end else begin
        toReduce = 1'b1;
      end
    end else begin
      if (a == b) begin
        // a never exceeds the original operands shifted right by k, so this cannot overflow.
        done   = 1'b1;
        result = a << k;
      end else if (!a[0]) begin
        aNext = a >> 1;
      end else if (!b[0]) begin
        bNext = b >> 1;
      end else if (a > b) begin
        aNext = a - b;
      end else begin
        bNext = b - a;
      end
    end
  end

endmodule

// File: rtl/gcd_engine.sv
`timescale 1ns/1ps
// Binary GCD engine with tagged request/result handshakes and a per-operation cycle count.
// Latency: at most 3*WIDTH+3 cycles from acceptance to out_valid (2 when an operand is 0).
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic [CYC_W-1:0] out_cycles
);

  localparam int KW = $clog2(WIDTH);

  gcdState_e        state;
  gcdState_e        stateNext;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [KW-1:0]    kReg;
  logic [TAG_W-1:0] tagReg;
  logic [CYC_W-1:0] cycCnt;
  logic [WIDTH-1:0] gcdReg;
  logic             zeroReg;
  logic [WIDTH-1:0] aNext;
  logic [WIDTH-1:0] bNext;
  logic [KW-1:0]    kNext;
  logic             stepDone;
  logic             stepToReduce;
  logic [WIDTH-1:0] stepResult;
  logic             stepBothZero;
  logic             accept;
  logic             busy;

  // Gating with reset keeps acceptance impossible while reset is held.
  assign in_ready   = (state == IDLE) && reset;
  assign accept     = in_valid && in_ready && !clear;
  assign busy       = (state == SHIFT) || (state == REDUCE);
  assign out_valid  = (state == DONE);
  assign out_gcd    = gcdReg;
  assign out_tag    = tagReg;
  assign out_zero   = zeroReg;
  assign out_cycles = cycCnt;

  gcd_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) uStep (
    .reduceMode (state == REDUCE),
    .a          (aReg),
    .b          (bReg),
    .k          (kReg),
    .aNext      (aNext),
    .bNext      (bNext),
    .kNext      (kNext),
    .done       (stepDone),
    .toReduce   (stepToReduce),
    .result     (stepResult),
    .bothZero   (stepBothZero)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic; clear overrides every transition including both handshakes.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (accept) stateNext = SHIFT;
      SHIFT: begin
        if (stepDone)          stateNext = DONE;
        else if (stepToReduce) stateNext = REDUCE;
      end
      REDUCE:  if (stepDone) stateNext = DONE;
      DONE:    if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (clear) stateNext = IDLE;
  end

  // Operand, counter and result registers: load on accept, step while busy, hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aReg    <= '0;
      bReg    <= '0;
      kReg    <= '0;
      tagReg  <= '0;
      cycCnt  <= '0;
      gcdReg  <= '0;
      zeroReg <= 1'b0;
    end else if (!clear) begin
      if (accept) begin
        aReg   <= in_a;
        bReg   <= in_b;
        tagReg <= in_tag;
        kReg   <= '0;
        cycCnt <= '0;
      end else if (busy) begin
        aReg   <= aNext;
        bReg   <= bNext;
        kReg   <= kNext;
        cycCnt <= (&cycCnt) ? cycCnt : cycCnt + CYC_W'(1);
        if (stepDone) begin
          gcdReg  <= stepResult;
          zeroReg <= stepBothZero;
        end
      end
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
`timescale 1ns/1ps
module tb_gcd_engine;
  import gcd_pkg::*;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int CYC_W = 16;
  localparam int BOUND = latencyBound(WIDTH);

  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
  logic [CYC_W-1:0] out_cycles;

  int tests = 0;
  int fails = 0;

  gcd_engine #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CYC_W(CYC_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_gcd    (out_gcd),
    .out_tag    (out_tag),
    .out_zero   (out_zero),
    .out_cycles (out_cycles)
  );

  always #5 clk = ~clk;

  // Euclid's algorithm by remainder: independent of the engine's binary method.
  function automatic logic [WIDTH-1:0] refGcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  // Present a request and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic sendReq(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
    int w;
    in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1; w = 0;
    while (!in_ready && w < BOUND + 20) begin
      @(posedge clk); #1; w++;
    end
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL accept_timeout in_ready=%0b after %0d cycles, required 1", in_ready, w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // n = clock edges after the accepting edge until out_valid is seen; the
  // result is then in the (n+1)-th cycle after the acceptance cycle.
  task automatic waitResult(output int n);
    n = 0;
    while (!out_valid && n < BOUND + 10) begin
      @(posedge clk); #1; n++;
    end
    tests++;
    if (!out_valid) begin
      fails++;
      $display("FAIL result_timeout out_valid=%0b after %0d cycles, required 1", out_valid, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'd9; in_b = 32'd6; in_tag = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b0)   begin fails++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    tests++; if (out_gcd !== '0)      begin fails++; $display("FAIL reset_out_gcd got %0d want 0", out_gcd); end
    tests++; if (out_tag !== '0)      begin fails++; $display("FAIL reset_out_tag got %0d want 0", out_tag); end
    tests++; if (out_zero !== 1'b0)   begin fails++; $display("FAIL reset_out_zero got %0b want 0", out_zero); end
    tests++; if (out_cycles !== '0)   begin fails++; $display("FAIL reset_out_cycles got %0d want 0", out_cycles); end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1)   begin fails++; $display("FAIL reset_release_in_ready got %0b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int n;
    out_ready = 1'b1;
    sendReq(32'd12, 32'd18, 4'd3);
    waitResult(n);
    tests++; if (out_gcd !== 32'd6)  begin fails++; $display("FAIL basic_gcd got %0d want 6", out_gcd); end
    tests++; if (out_tag !== 4'd3)   begin fails++; $display("FAIL basic_tag got %0d want 3", out_tag); end
    tests++; if (out_zero !== 1'b0)  begin fails++; $display("FAIL basic_zero got %0b want 0", out_zero); end
    tests++; if (out_cycles == 0 || int'(out_cycles) > BOUND)
      begin fails++; $display("FAIL basic_cycles got %0d want 1..%0d", out_cycles, BOUND); end
    tests++; if (int'(out_cycles) != n)
      begin fails++; $display("FAIL basic_cycles_vs_observed got %0d want %0d", out_cycles, n); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    logic [WIDTH-1:0] av [3];
    logic [WIDTH-1:0] bv [3];
    int n;
    av = '{32'd0, 32'd0, 32'd35};
    bv = '{32'd0, 32'd35, 32'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sendReq(av[i], bv[i], 4'(i + 4));
      waitResult(n);
      tests++; if (out_gcd !== (av[i] | bv[i]))
        begin fails++; $display("FAIL zero_gcd[%0d] got %0d want %0d", i, out_gcd, av[i] | bv[i]); end
      tests++; if (out_zero !== (i == 0))
        begin fails++; $display("FAIL zero_flag[%0d] got %0b want %0b", i, out_zero, i == 0); end
      tests++; if (n + 1 != 2)
        begin fails++; $display("FAIL zero_latency[%0d] got %0d want 2", i, n + 1); end
      tests++; if (out_cycles !== 16'd1)
        begin fails++; $display("FAIL zero_cycles[%0d] got %0d want 1", i, out_cycles); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [WIDTH-1:0] a, b, exp;
    a = 32'h1 << (WIDTH - 1);
    b = 32'h1 << (WIDTH - 2);
    exp = b;
    out_ready = 1'b0;
    sendReq(a, b, 4'd10);
    waitResult(n);
    for (int i = 0; i < 10; i++) begin
      tests++; if (out_valid !== 1'b1 || out_gcd !== exp || out_tag !== 4'd10 || in_ready !== 1'b0)
        begin fails++; $display("FAIL hold[%0d] valid=%0b gcd=%0h tag=%0d in_ready=%0b want 1/%0h/10/0",
                                 i, out_valid, out_gcd, out_tag, in_ready, exp); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL hold_release_valid got %0b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL hold_release_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_max_latency();
    int n;
    out_ready = 1'b1;
    sendReq(32'hFFFF_FFFF, 32'd1, 4'd11);
    waitResult(n);
    tests++; if (out_gcd !== 32'd1) begin fails++; $display("FAIL maxlat_gcd got %0d want 1", out_gcd); end
    tests++; if (n + 1 > BOUND)     begin fails++; $display("FAIL maxlat_latency got %0d want <=%0d", n + 1, BOUND); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int n;
    logic [WIDTH-1:0] a1, b1, a2, b2;
    a1 = $urandom_range(1, 100000) * 32'd6;
    b1 = $urandom_range(1, 100000) * 32'd4;
    a2 = $urandom_range(1, 100000) * 32'd15;
    b2 = $urandom_range(1, 100000) * 32'd9;
    out_ready = 1'b1;
    sendReq(a1, b1, 4'd1);
    waitResult(n);
    tests++; if (out_gcd !== refGcd(a1, b1))
      begin fails++; $display("FAIL b2b_gcd1 got %0d want %0d", out_gcd, refGcd(a1, b1)); end
    tests++; if (in_ready !== 1'b0)
      begin fails++; $display("FAIL b2b_handshake_in_ready got %0b want 0", in_ready); end
    in_a = a2; in_b = b2; in_tag = 4'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin fails++; $display("FAIL b2b_idle_cycle valid=%0b in_ready=%0b want 0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++; if (in_ready !== 1'b0)
      begin fails++; $display("FAIL b2b_accepted in_ready=%0b want 0", in_ready); end
    waitResult(n);
    tests++; if (out_gcd !== refGcd(a2, b2) || out_tag !== 4'd2)
      begin fails++; $display("FAIL b2b_gcd2 got %0d tag %0d want %0d tag 2", out_gcd, out_tag, refGcd(a2, b2)); end
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    int n;
    bit seen;
    out_ready = 1'b1;
    sendReq(32'd48, 32'd180, 4'd6);
    @(posedge clk); @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL clear_in_ready got %0b want 1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    tests++; if (seen) begin fails++; $display("FAIL clear_no_result saw out_valid=1 want none"); end
    sendReq(32'd7, 32'd21, 4'd7);
    waitResult(n);
    tests++; if (out_gcd !== 32'd7 || out_tag !== 4'd7)
      begin fails++; $display("FAIL clear_next_gcd got %0d tag %0d want 7 tag 7", out_gcd, out_tag); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int n;
    logic [WIDTH-1:0] a, b, c, exp;
    logic [TAG_W-1:0] tag;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      c = $urandom_range(1, 255);
      a = ($urandom >> $urandom_range(8, 31)) * c;
      b = ($urandom >> $urandom_range(8, 31)) * c;
      if ($urandom_range(0, 7) == 0) a = '0;
      if ($urandom_range(0, 7) == 0) b = '0;
      tag = TAG_W'($urandom);
      exp = refGcd(a, b);
      sendReq(a, b, tag);
      waitResult(n);
      tests++; if (out_gcd !== exp || out_tag !== tag || out_zero !== (a == 0 && b == 0))
        begin fails++; $display("FAIL rand[%0d] a=%0d b=%0d got gcd=%0d tag=%0d zero=%0b want %0d/%0d/%0b",
                                 i, a, b, out_gcd, out_tag, out_zero, exp, tag, a == 0 && b == 0); end
      tests++; if (int'(out_cycles) != n || n + 1 > BOUND)
        begin fails++; $display("FAIL rand_cycles[%0d] got %0d observed %0d bound %0d", i, out_cycles, n, BOUND); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    int n;
    out_ready = 1'b1;
    sendReq(32'hFFFF_FFFF, 32'd1, 4'd9);
    repeat (6) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_gcd !== '0 || out_tag !== '0 || out_zero !== 1'b0 ||
                 out_cycles !== '0 || in_ready !== 1'b0)
      begin fails++; $display("FAIL async_reset valid=%0b gcd=%0d tag=%0d zero=%0b cyc=%0d in_ready=%0b want all 0",
                               out_valid, out_gcd, out_tag, out_zero, out_cycles, in_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL async_release_in_ready got %0b want 1", in_ready); end
    sendReq(32'd100, 32'd75, 4'd12);
    waitResult(n);
    tests++; if (out_gcd !== 32'd25) begin fails++; $display("FAIL post_reset_gcd got %0d want 25", out_gcd); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_max_latency();
    test_back_to_back();
    test_clear();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
